// File: rtl/word_upsizer_pkg.sv
// Shared constants and helpers for the narrow-to-wide word packer.
package word_upsizer_pkg;

    // First narrow word received lands in the least-significant lane.
    localparam bit LANE_LSB_FIRST = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // A full wide word reports every lane valid.
    function automatic int lanes_rst_val(input int ratio);
        return ratio;
    endfunction

endpackage

// File: rtl/word_upsizer_out.sv
// Output/credit stage: holds one wide word; enqueues when the previous-cycle FULL_N allowed it.
// Latency: load -> enq one cycle later at best; stalls while ok_q is low, new load accepted on the enq cycle.
module word_upsizer_out
    import word_upsizer_pkg::*;
#(
    parameter int width = 8,
    parameter int ratio = 4,
    parameter int cntw  = clog2(ratio)
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic                    load,
    input  logic [width*ratio-1:0]  load_d,
    input  logic [cntw:0]           load_lanes,
    input  logic                    full_n,
    output logic [width*ratio-1:0]  d_out,
    output logic [cntw:0]           lanes,
    output logic                    enq,
    output logic                    out_valid
);

    logic [width*ratio-1:0] out_reg;
    logic [cntw:0]          lanes_reg;
    logic                   ok_q;

    assign enq   = out_valid & ok_q;
    assign d_out = out_reg;
    assign lanes = lanes_reg;

    // Downstream FULL_N reacts combinationally to its own ENQ, so only last cycle's value grants a credit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            ok_q      <= 1'b0;
            lanes_reg <= (cntw+1)'(lanes_rst_val(ratio));
        end else begin
            ok_q <= full_n;
            if (CLR)
                out_valid <= 1'b0;
            else if (load)
                out_valid <= 1'b1;
            else if (enq)
                out_valid <= 1'b0;
            if (load)
                lanes_reg <= load_lanes;
        end
    end

    always_ff @(posedge CLK) begin
        if (load)
            out_reg <= load_d;
    end

endmodule

// File: rtl/word_upsizer.sv
// Packs ratio narrow words (LSB lane first) into one wide word; one narrow word per cycle.
// Latency: last narrow word dequeued in cycle t -> M_ENQ in t+1 at the earliest.
// Backpressure: upstream held when a complete word cannot be handed over; WORD_UPSIZER_FLUSH_EN adds partial-word flush.
module word_upsizer
    import word_upsizer_pkg::*;
#(
    parameter int width = 8,
    parameter int ratio = 4,
    parameter int cntw  = clog2(ratio)
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [width-1:0]        S_D,
    input  logic                    S_EMPTY_N,
    output logic                    S_DEQ,
    output logic [width*ratio-1:0]  M_D_OUT,
    output logic                    M_ENQ,
    input  logic                    M_FULL_N,
    input  logic                    CLR,
    input  logic                    FLUSH,
    output logic [cntw:0]           M_LANES
);

    logic [width*(ratio-1)-1:0] acc;
    logic [width*ratio-1:0]     acc_ext;
    logic [width*ratio-1:0]     load_d;
    logic [cntw:0]              load_lanes;
    logic [cntw-1:0]            cnt;
    logic                       complete;
    logic                       s_deq;
    logic                       load;
    logic                       enq;
    logic                       out_valid;

    assign complete = (cnt == cntw'(ratio-1));
    assign s_deq    = S_EMPTY_N & !RST & !CLR & (!complete | !out_valid | enq);
    assign S_DEQ    = s_deq;
    assign M_ENQ    = enq;
    assign acc_ext  = {{width{1'b0}}, acc};

`ifdef WORD_UPSIZER_FLUSH_EN
    logic flush_pend;
    logic flush_go;

    assign flush_go   = flush_pend & (!out_valid | enq) & !CLR;
    assign load       = (s_deq & complete) | (flush_go & ((cnt != '0) | s_deq));
    assign load_lanes = {1'b0, cnt} + (cntw+1)'(s_deq);

    // A flush opportunity always retires the request, whether or not anything was held.
    always_ff @(posedge CLK) begin
        if (RST || CLR)
            flush_pend <= 1'b0;
        else
            flush_pend <= (flush_pend & !flush_go) | FLUSH;
    end
`else
    logic flush_unused;

    assign flush_unused = FLUSH;
    assign load         = s_deq & complete;
    assign load_lanes   = (cntw+1)'(lanes_rst_val(ratio));
`endif

    // Lanes below cnt come from acc, lane cnt takes the word dequeued now, the rest are zero.
    always_comb begin
        load_d = '0;
        for (int k = 0; k < ratio; k++) begin
            if (k < int'(cnt))
                load_d[k*width +: width] = acc_ext[k*width +: width];
            else if (k == int'(cnt) && s_deq)
                load_d[k*width +: width] = S_D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (s_deq)
            cnt <= cnt + cntw'(1);
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < ratio-1; k++) begin
            if (s_deq && !complete && cnt == cntw'(k))
                acc[k*width +: width] <= S_D;
        end
    end

    word_upsizer_out #(
        .width (width),
        .ratio (ratio),
        .cntw  (cntw)
    ) u_out (
        .CLK        (CLK),
        .RST        (RST),
        .CLR        (CLR),
        .load       (load),
        .load_d     (load_d),
        .load_lanes (load_lanes),
        .full_n     (M_FULL_N),
        .d_out      (M_D_OUT),
        .lanes      (M_LANES),
        .enq        (enq),
        .out_valid  (out_valid)
    );

endmodule

// File: tb/tb_word_upsizer.sv
// Bench for word_upsizer (width=8, ratio=4): directed scenarios plus random traffic against a byte-grouping model.
module tb_word_upsizer;
    import word_upsizer_pkg::*;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int CW = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [W-1:0]    S_D;
    logic            S_EMPTY_N;
    logic            S_DEQ;
    logic [W*R-1:0]  M_D_OUT;
    logic            M_ENQ;
    logic            M_FULL_N;
    logic            CLR;
    logic            FLUSH;
    logic [CW:0]     M_LANES;

    always #5 CLK = ~CLK;

    word_upsizer #(.width(W), .ratio(R), .cntw(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .S_D       (S_D),
        .S_EMPTY_N (S_EMPTY_N),
        .S_DEQ     (S_DEQ),
        .M_D_OUT   (M_D_OUT),
        .M_ENQ     (M_ENQ),
        .M_FULL_N  (M_FULL_N),
        .CLR       (CLR),
        .FLUSH     (FLUSH),
        .M_LANES   (M_LANES)
    );

`ifdef WORD_UPSIZER_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Upstream contents, model partial word, expected wide words, observation logs.
    logic [7:0]  src_q[$];
    logic [7:0]  buf_q[$];
    logic [31:0] exp_d[$];
    int          exp_l[$];
    logic [31:0] enq_log[$];
    int          lanes_log[$];
    int          enq_cyc[$];
    int          deq_cyc[$];

    int cyc         = 0;
    bit prev_full_n = 1'b0;
    bit src_gate    = 1'b1;
    bit force_src   = 1'b1;
    bit full_n_cfg  = 1'b1;
    bit rst_cfg     = 1'b1;
    int base;
    int d0;
    int rel;

    function automatic void model_emit();
        logic [31:0] word;
        word = '0;
        foreach (buf_q[i])
            word[8*(LANE_LSB_FIRST ? i : R-1-i) +: 8] = buf_q[i];
        exp_d.push_back(word);
        exp_l.push_back(buf_q.size());
        buf_q.delete();
    endfunction

    // Drive one cycle's inputs at the falling edge, then observe what the next rising edge will commit.
    task automatic step(input bit flush = 1'b0, input bit clr = 1'b0);
        @(negedge CLK);
        RST      = rst_cfg;
        FLUSH    = flush;
        CLR      = clr;
        M_FULL_N = full_n_cfg;
        if (force_src) begin
            S_EMPTY_N = 1'b1;
            S_D       = 8'hEE;
        end else begin
            S_EMPTY_N = src_gate && (src_q.size() > 0);
            S_D       = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        end
        #1;
        if (M_ENQ) begin
            chk("enq_credit", prev_full_n, 1);
            enq_log.push_back(M_D_OUT);
            lanes_log.push_back(int'(M_LANES));
            enq_cyc.push_back(cyc);
            if (exp_d.size() == 0)
                chk("enq_unexpected", M_ENQ, 0);
            else begin
                chk("enq_data", M_D_OUT, exp_d.pop_front());
                chk("enq_lanes", M_LANES, exp_l.pop_front());
            end
        end
        if (S_DEQ) begin
            chk("deq_nonempty", S_EMPTY_N, 1);
            if (!force_src && src_q.size() > 0) begin
                buf_q.push_back(src_q.pop_front());
                deq_cyc.push_back(cyc);
                if (buf_q.size() == R) model_emit();
            end
        end
        if (clr) buf_q.delete();
        if (flush && FLUSH_ON && buf_q.size() > 0) model_emit();
        prev_full_n = M_FULL_N;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; CLR = 1'b0; FLUSH = 1'b0; S_EMPTY_N = 1'b0; S_D = '0; M_FULL_N = 1'b0;

        // Reset held two cycles with upstream claiming data.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_deq", S_DEQ, 0);
            chk("rst_enq", M_ENQ, 0);
            chk("rst_lanes", M_LANES, 4);
        end
        rst_cfg   = 1'b0;
        force_src = 1'b0;
        step();
        chk("post_rst_enq", M_ENQ, 0);
        chk("post_rst_lanes", M_LANES, 4);
        chk("post_rst_deq", S_DEQ, 0);
        step();

        // Back-to-back streaming.
        base = enq_log.size();
        d0   = deq_cyc.size();
        for (int b = 1; b <= 8; b++) src_q.push_back(8'(b * 17));
        run(12);
        chk("stream_cnt", enq_log.size() - base, 2);
        chk("deq_count", deq_cyc.size() - d0, 8);
        if (enq_log.size() >= base + 2) begin
            chk("stream_w0", enq_log[base], 32'h44332211);
            chk("stream_w1", enq_log[base+1], 32'h88776655);
            chk("stream_gap", enq_cyc[base+1] - enq_cyc[base], 4);
        end
        if (deq_cyc.size() >= d0 + 8 && enq_log.size() > base) begin
            chk("deq_run", deq_cyc[d0+7] - deq_cyc[d0], 7);
            chk("first_latency", enq_cyc[base] - deq_cyc[d0+3], 1);
        end

        // Downstream stall while the second word completes.
        base = enq_log.size();
        for (int b = 1; b <= 12; b++) src_q.push_back(8'(b * 17));
        for (int i = 0; i < 20 && enq_log.size() < base + 1; i++) step();
        chk("stall_first", enq_log.size() - base, 1);
        full_n_cfg = 1'b0;
        run(10);
        chk("stall_noenq", enq_log.size() - base, 1);
        chk("stall_held", src_q.size(), 1);
        chk("stall_deq", S_DEQ, 0);
        full_n_cfg = 1'b1;
        rel = cyc;
        run(8);
        chk("stall_cnt", enq_log.size() - base, 3);
        if (enq_log.size() >= base + 3) begin
            chk("stall_resume", enq_cyc[base+1] - rel, 1);
            chk("stall_w1", enq_log[base+1], 32'h88776655);
            chk("stall_w2", enq_log[base+2], 32'hCCBBAA99);
        end

        // Partial word and flush request.
        base = enq_log.size();
        src_q.push_back(8'hA1);
        src_q.push_back(8'hB2);
        run(6);
        chk("flush_pre", enq_log.size() - base, 0);
        step(1'b1);
        run(6);
        if (FLUSH_ON) begin
            chk("flush_cnt", enq_log.size() - base, 1);
            if (enq_log.size() > base) begin
                chk("flush_data", enq_log[base], 32'h0000B2A1);
                chk("flush_lanes", lanes_log[base], 2);
            end
            step(1'b1);
            run(6);
            chk("flush_empty", enq_log.size() - base, 1);
        end else begin
            chk("noflush_cnt", enq_log.size() - base, 0);
            src_q.push_back(8'hC3);
            src_q.push_back(8'hD4);
            run(6);
            chk("noflush_done", enq_log.size() - base, 1);
            if (enq_log.size() > base) begin
                chk("noflush_data", enq_log[base], 32'hD4C3B2A1);
                chk("noflush_lanes", lanes_log[base], 4);
            end
        end

        // Clear discards a half-built word.
        base = enq_log.size();
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        run(4);
        step(1'b0, 1'b1);
        for (int b = 1; b <= 4; b++) src_q.push_back(8'(b * 16));
        run(8);
        chk("clr_cnt", enq_log.size() - base, 1);
        if (enq_log.size() > base)
            chk("clr_data", enq_log[base], 32'h40302010);

        // Random upstream gaps and downstream stalls.
        base = enq_log.size();
        for (int b = 0; b < 400; b++) src_q.push_back(8'($urandom));
        for (int i = 0; i < 5000; i++) begin
            src_gate   = ($urandom_range(0, 3) != 0);
            full_n_cfg = ($urandom_range(0, 9) < 7);
            step();
            if (src_q.size() == 0 && exp_d.size() == 0) break;
        end
        src_gate   = 1'b1;
        full_n_cfg = 1'b1;
        chk("rand_drain", src_q.size() + exp_d.size() + buf_q.size(), 0);
        chk("rand_words", enq_log.size() - base, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/word_upsizer.md
Name: word_upsizer

Overview:
- Narrow-to-wide gearbox between two depth-2 pipelined-full FIFOs.
- Dequeues `width`-bit words from the upstream FIFO's D_OUT/EMPTY_N/DEQ side.
- Packs `ratio` consecutive words into one `width*ratio` word and enqueues it into the downstream FIFO's D_IN/ENQ/FULL_N side.
- Sustains one narrow word per cycle; no combinational path from M_FULL_N to any output.

Parameters:
- width, 8, narrow word width in bits (>=1).
- ratio, 4, narrow words per wide word; power of two, 2..16.
- cntw, 2, log2(ratio); lane counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- S_D  in  width  upstream FIFO D_OUT.
- S_EMPTY_N  in  1  upstream FIFO EMPTY_N (registered at source).
- S_DEQ  out  1  dequeue strobe to upstream FIFO.
- M_D_OUT  out  width*ratio  wide word to downstream FIFO D_IN.
- M_ENQ  out  1  enqueue strobe to downstream FIFO.
- M_FULL_N  in  1  downstream pipelined full flag ("ENQ allowed next cycle").
- CLR  in  1  synchronous clear; discards all held data.
- FLUSH  in  1  one-cycle pulse requesting emission of a partial word.
- M_LANES  out  cntw+1  count of valid lanes in M_D_OUT, valid while M_ENQ is high.

Behaviour:
- State registers:
  - acc: width*(ratio-1).
  - cnt: cntw bits, lanes held in acc.
  - out_reg: width*ratio.
  - lanes_reg.
  - out_valid.
  - ok_q: registered M_FULL_N.
  - flush_pend.
- Reset values: cnt=0, out_valid=0, ok_q=0, flush_pend=0, lanes_reg=ratio. Hence S_DEQ=0, M_ENQ=0, M_LANES=ratio. acc/out_reg are not reset.
- Credit rule:
  - ok_q <= M_FULL_N every cycle.
  - M_ENQ = out_valid & ok_q.
  - M_FULL_N sampled in cycle t authorises ENQ in cycle t+1. This is mandatory because the downstream FULL_N depends combinationally on its own ENQ.
- M_D_OUT = out_reg; M_LANES = lanes_reg.
- complete = (cnt==ratio-1).
- S_DEQ = S_EMPTY_N & !CLR & (!complete | !out_valid | M_ENQ).
- Lane order: first word received occupies bits [width-1:0]; lane k occupies [width*(k+1)-1 : width*k].
- On S_DEQ & !complete: acc lane cnt <= S_D; cnt <= cnt+1.
- On S_DEQ & complete:
  - out_reg <= {S_D, acc}; lanes_reg <= ratio; out_valid <= 1; cnt <= 0.
  - Latency: last narrow word dequeued in cycle t -> M_ENQ earliest cycle t+1.
- On M_ENQ with no new load: out_valid <= 0. M_ENQ and a new load in the same cycle leave out_valid=1 (back-to-back wide words).
- CLR (RST has priority over CLR):
  - cnt=0, out_valid=0, flush_pend=0; S_DEQ forced 0 that cycle.
  - M_ENQ in the CLR cycle still occurs if out_valid & ok_q. ok_q still tracks M_FULL_N.
- Wrap: cnt wraps ratio-1 -> 0 only via complete load.
- Downstream stall (ok_q=0) with complete & out_valid: S_DEQ=0, upstream holds. No data loss or duplication.
- Upstream empty: cnt holds; partial words never emitted without flush.

Optional Feature:
- Macro: WORD_UPSIZER_FLUSH_EN.
- With the macro defined:
  - FLUSH pulse sets flush_pend.
  - When flush_pend & (!out_valid | M_ENQ):
    - If cnt>0 and no S_DEQ this cycle: out_reg <= zero-padded acc, lanes_reg <= cnt, out_valid <= 1, cnt <= 0, flush_pend <= 0.
    - If S_DEQ occurs that cycle: the dequeued word is included; emitted lanes = cnt+1; a complete load counts as the flush.
    - If cnt==0 and no S_DEQ: flush_pend clears, nothing emitted.
  - Unused lanes are zero.
- Without the macro: FLUSH ignored, flush_pend constant 0, M_LANES constant ratio.

Decomposition:
- Shared package holds:
  - lane-order constant (LSB-first);
  - clog2 function for cntw / M_LANES widths;
  - reset-value constants for the lane count.
- One natural sub-module: word_upsizer_out, the out_reg/out_valid/ok_q credit stage. It takes a load strobe, data and lanes, and returns an M_ENQ-this-cycle indication to the packer.

Test Plan (width=8, ratio=4):
- Reset: hold RST 2 cycles with S_EMPTY_N=1 -> S_DEQ=0, M_ENQ=0, M_LANES=4 throughout and one cycle after release.
- Streaming: upstream supplies 0x11,0x22,0x33,0x44,0x55..0x88 back-to-back, M_FULL_N=1 -> M_ENQ with 0x44332211 then 0x88776655 exactly 4 cycles apart, S_DEQ high 8 consecutive cycles.
- Stall: M_FULL_N=0 while second wide word completes -> S_DEQ drops with cnt=3; no M_ENQ. M_FULL_N=1 -> M_ENQ next cycle with 0x88776655; no lost or duplicated lanes.
- Flush (macro on): 0xA1,0xB2 then FLUSH -> M_ENQ 0x0000B2A1, M_LANES=2. A following FLUSH with cnt=0 -> no M_ENQ.
- Flush (macro off): same stimulus -> no M_ENQ until two more words arrive, then 0xD4C3B2A1 (with 0xC3,0xD4 supplied), M_LANES=4.
- CLR mid-word: after 0x01,0x02, pulse CLR, then 0x10,0x20,0x30,0x40 -> only M_ENQ data is 0x40302010.
